// File: rtl/vga_sync_decoder_if.sv
// Video sink bundle: sampled VGA sync/colour inputs plus the decoded pixel stream.
interface vga_sync_decoder_if;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [7:0] pix_rgb;
  logic       pix_valid;
  logic       frame_start;
  logic       locked;
  logic [7:0] err_cnt;

  modport master (
    output hsync, vsync, red, green, blue,
    input  pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, err_cnt
  );

  modport slave (
    input  hsync, vsync, red, green, blue,
    output pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, err_cnt
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sink: rebuilds h/v position from the sync pulses, checks the timing mode,
// locks after consecutive good frames and emits active-area pixel coordinates.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 521,
  parameter int HBP         = 144,
  parameter int HFP         = 784,
  parameter int VBP         = 31,
  parameter int VFP         = 511,
  parameter int LOCK_FRAMES = 2
) (
  input logic               dclk,
  input logic               clr_n,
  vga_sync_decoder_if.slave vid
);

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [9:0]  HBP_W     = 10'(HBP);
  localparam logic [9:0]  HFP_W     = 10'(HFP);
  localparam logic [9:0]  VBP_W     = 10'(VBP);
  localparam logic [9:0]  VFP_W     = 10'(VFP);
  localparam logic [7:0]  LOCK_W    = 8'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX   = 10'h3FF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       hs_d, vs_line, seen_hfall, line_bad;
  logic [9:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
  logic [7:0] good_cnt, good_nxt;
  logic       hfall, vevent, len_bad, h_sat, bad_line, bad_frame;
  logic       err_inc, active, valid_nxt;
  logic [7:0] err_q, err_nxt, rgb_nxt;
  logic [9:0] x_nxt, y_nxt;
  logic [9:0] pix_x_q, pix_y_q;
  logic [7:0] pix_rgb_q;
  logic       pix_valid_q, frame_start_q, locked_q;

  // A frame boundary is only recognised at a line start, so a mid-line vsync
  // fall waits for the next hsync fall before it counts.
  always_comb begin
    hfall  = hs_d & ~vid.hsync;
    vevent = hfall & ~vid.vsync & vs_line;

    hcnt_nxt = hcnt;
    if (hfall)
      hcnt_nxt = '0;
    else if (hcnt != CNT_MAX)
      hcnt_nxt = hcnt + 10'd1;

    vcnt_nxt = vcnt;
    if (vevent)
      vcnt_nxt = '0;
    else if (hfall && (vcnt != CNT_MAX))
      vcnt_nxt = vcnt + 10'd1;

    len_bad   = hfall & seen_hfall & (({1'b0, hcnt} + 11'd1) != H_TOTAL_W);
    h_sat     = ~hfall & (hcnt == (CNT_MAX - 10'd1));
    bad_line  = len_bad | h_sat;
    bad_frame = vevent & ((({1'b0, vcnt} + 11'd1) != V_TOTAL_W) | line_bad | bad_line);
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hs_d       <= 1'b0;
      vs_line    <= 1'b0;
      seen_hfall <= 1'b0;
      line_bad   <= 1'b0;
      hcnt       <= '0;
      vcnt       <= '0;
    end else begin
      hs_d <= vid.hsync;
      if (hfall) begin
        vs_line    <= vid.vsync;
        seen_hfall <= 1'b1;
      end
      line_bad <= vevent ? 1'b0 : (line_bad | bad_line);
      hcnt     <= hcnt_nxt;
      vcnt     <= vcnt_nxt;
    end
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    case (state)
      SEARCH: begin
        if (vevent) begin
          state_nxt = MEASURE;
          good_nxt  = '0;
        end
      end
      MEASURE: begin
        if (vevent) begin
          if (bad_frame) begin
            good_nxt = '0;
          end else begin
            good_nxt = good_cnt + 8'd1;
            if ((good_cnt + 8'd1) >= LOCK_W)
              state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (bad_line | bad_frame)
          state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // A bad line coinciding with a bad frame is a single error.
  always_comb begin
    err_inc   = ((state == MEASURE) & bad_frame) |
                ((state == LOCKED) & (bad_line | bad_frame));
    err_nxt   = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    active    = (hcnt_nxt >= HBP_W) && (hcnt_nxt < HFP_W) &&
                (vcnt_nxt >= VBP_W) && (vcnt_nxt < VFP_W);
    valid_nxt = (state_nxt == LOCKED) && active;
    x_nxt     = valid_nxt ? (hcnt_nxt - HBP_W) : '0;
    y_nxt     = valid_nxt ? (vcnt_nxt - VBP_W) : '0;
    rgb_nxt   = valid_nxt ? {vid.red, vid.green, vid.blue} : '0;
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= '0;
    end else begin
      pix_x_q       <= x_nxt;
      pix_y_q       <= y_nxt;
      pix_rgb_q     <= rgb_nxt;
      pix_valid_q   <= valid_nxt;
      frame_start_q <= vevent;
      locked_q      <= (state_nxt == LOCKED);
      err_q         <= err_nxt;
    end
  end

  assign vid.pix_x       = pix_x_q;
  assign vid.pix_y       = pix_y_q;
  assign vid.pix_rgb     = pix_rgb_q;
  assign vid.pix_valid   = pix_valid_q;
  assign vid.frame_start = frame_start_q;
  assign vid.locked      = locked_q;
  assign vid.err_cnt     = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a scaled-down VGA mode generator with random colour and
// timing faults, checked every cycle against an integer reference model plus directed spot checks.
module tb_vga_sync_decoder;

  localparam int H_TOTAL     = 20;
  localparam int V_TOTAL     = 8;
  localparam int HBP         = 4;
  localparam int HFP         = 18;
  localparam int VBP         = 3;
  localparam int VFP         = 7;
  localparam int LOCK_FRAMES = 2;
  localparam int HSW         = 2;
  localparam int VSW         = 2;

  localparam int S_SEARCH  = 0;
  localparam int S_MEASURE = 1;
  localparam int S_LOCKED  = 2;

  logic dclk  = 1'b0;
  logic clr_n = 1'b1;

  vga_sync_decoder_if vid();

  vga_sync_decoder #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HBP(HBP), .HFP(HFP),
    .VBP(VBP), .VFP(VFP), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .dclk  (dclk),
    .clr_n (clr_n),
    .vid   (vid)
  );

  always #20 dclk = ~dclk;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state, all plain integers
  int mHsd, mVsLine, mSeen, mLineBad, mState, mGood, mErr, mH, mV;
  int eX, eY, eErr;
  logic [7:0] eRgb;
  logic eValid, eFs, eLocked;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [63:0] packObs();
    return {25'd0, vid.pix_x, vid.pix_y, vid.pix_rgb, vid.pix_valid,
            vid.frame_start, vid.locked, vid.err_cnt};
  endfunction

  function automatic logic [63:0] packExp();
    return {25'd0, 10'(eX), 10'(eY), eRgb, eValid, eFs, eLocked, 8'(eErr)};
  endfunction

  task automatic modelReset();
    mHsd = 0; mVsLine = 0; mSeen = 0; mLineBad = 0;
    mState = S_SEARCH; mGood = 0; mErr = 0; mH = 0; mV = 0;
    eX = 0; eY = 0; eErr = 0; eRgb = '0; eValid = 0; eFs = 0; eLocked = 0;
  endtask

  // Predicts the outputs visible after the edge that samples these inputs
  task automatic modelStep(input logic hs, input logic vs, input logic [7:0] rgb);
    bit hfall, vevent, badLine, badFrame, counted;
    int newH, newV;
    if (clr_n == 1'b0) begin
      modelReset();
      return;
    end
    hfall  = (mHsd == 1) && (hs == 1'b0);
    vevent = hfall && (vs == 1'b0) && (mVsLine == 1);
    newH = hfall ? 0 : ((mH < 1023) ? mH + 1 : 1023);
    newV = vevent ? 0 : (hfall ? ((mV < 1023) ? mV + 1 : 1023) : mV);
    badLine  = (hfall && (mSeen == 1) && (mH + 1 != H_TOTAL)) || (newH == 1023 && mH != 1023);
    badFrame = vevent && ((mV + 1 != V_TOTAL) || (mLineBad == 1) || badLine);
    counted  = (mState == S_MEASURE && badFrame) || (mState == S_LOCKED && (badLine || badFrame));
    case (mState)
      S_SEARCH:
        if (vevent) begin
          mState = S_MEASURE;
          mGood  = 0;
        end
      S_MEASURE:
        if (vevent) begin
          if (badFrame) mGood = 0;
          else begin
            mGood++;
            if (mGood >= LOCK_FRAMES) mState = S_LOCKED;
          end
        end
      default:
        if (badLine || badFrame) mState = S_SEARCH;
    endcase
    if (counted && mErr < 255) mErr++;
    mLineBad = vevent ? 0 : ((mLineBad == 1 || badLine) ? 1 : 0);
    if (hfall) begin
      mSeen   = 1;
      mVsLine = vs;
    end
    mHsd = hs;
    mH   = newH;
    mV   = newV;
    eLocked = (mState == S_LOCKED);
    eValid  = eLocked && newH >= HBP && newH < HFP && newV >= VBP && newV < VFP;
    eX   = eValid ? newH - HBP : 0;
    eY   = eValid ? newV - VBP : 0;
    eRgb = eValid ? rgb : 8'd0;
    eFs  = vevent;
    eErr = mErr;
  endtask

  task automatic applyStimulus(input logic hs, input logic vs, input logic [7:0] rgb);
    vid.hsync = hs;
    vid.vsync = vs;
    vid.red   = rgb[7:5];
    vid.green = rgb[4:2];
    vid.blue  = rgb[1:0];
    modelStep(hs, vs, rgb);
    @(posedge dclk);
    #1;
    checkOutput("cycle", packObs(), packExp());
  endtask

  task automatic genPixel(input int vc, input int hc, input int len, input int nLines,
                          input bit earlyVs, input bit spots);
    logic hs, vs;
    logic [7:0] rgb;
    hs  = (hc >= HSW);
    vs  = !((vc < VSW) || (earlyVs && vc == nLines - 1 && hc >= len / 2));
    rgb = 8'($urandom_range(0, 255));
    if (spots && hc == HBP && vc == VBP) rgb = 8'hE0;
    applyStimulus(hs, vs, rgb);
    if (spots && hc == HBP && vc == VBP) begin
      checkOutput("first_pixel_valid", 64'(vid.pix_valid), 64'd1);
      checkOutput("first_pixel_x", 64'(vid.pix_x), 64'd0);
      checkOutput("first_pixel_y", 64'(vid.pix_y), 64'd0);
      checkOutput("first_pixel_rgb", 64'(vid.pix_rgb), 64'hE0);
    end
    if (spots && hc == HFP - 1 && vc == VFP - 1) begin
      checkOutput("last_pixel_x", 64'(vid.pix_x), 64'(HFP - HBP - 1));
      checkOutput("last_pixel_y", 64'(vid.pix_y), 64'(VFP - VBP - 1));
    end
    if (spots && hc == HFP && vc == VBP)
      checkOutput("front_porch_invalid", 64'(vid.pix_valid), 64'd0);
  endtask

  task automatic sendFrame(input int firstLine, input int nLines, input int shortLine,
                           input int shortLen, input bit earlyVs, input bit spots,
                           input int lockAtStart, input int errAfterShort);
    for (int vc = firstLine; vc < nLines; vc++) begin
      int len;
      len = (vc == shortLine) ? shortLen : H_TOTAL;
      for (int hc = 0; hc < len; hc++) begin
        genPixel(vc, hc, len, nLines, earlyVs, spots);
        if (vc == firstLine && hc == 0 && lockAtStart >= 0)
          checkOutput("lock_at_frame_start", 64'(vid.locked), 64'(lockAtStart));
        if (vc == shortLine + 1 && hc == 0 && errAfterShort >= 0) begin
          checkOutput("unlock_after_short_line", 64'(vid.locked), 64'd0);
          checkOutput("err_after_short_line", 64'(vid.err_cnt), 64'(errAfterShort));
        end
      end
    end
  endtask

  initial begin
    modelReset();
    vid.hsync = 1'b1; vid.vsync = 1'b1;
    vid.red = '0; vid.green = '0; vid.blue = '0;
    #2 clr_n = 1'b0;
    #3 checkOutput("reset_state", packObs(), 64'd0);
    modelReset();
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h00);
    clr_n = 1'b1;

    $display("[TB] ideal stream from reset");
    repeat (3) sendFrame(0, V_TOTAL, -1, 0, 1'b0, 1'b0, -1, -1);
    checkOutput("unlocked_before_third_vevent", 64'(vid.locked), 64'd0);
    checkOutput("no_errors_ideal", 64'(vid.err_cnt), 64'd0);

    $display("[TB] locked frame with pixel spot checks");
    sendFrame(0, V_TOTAL, -1, 0, 1'b0, 1'b1, 1, -1);

    $display("[TB] shortened line while locked");
    sendFrame(0, V_TOTAL, 3, H_TOTAL - 1, 1'b0, 1'b0, -1, 1);
    repeat (2) sendFrame(0, V_TOTAL, -1, 0, 1'b0, 1'b0, -1, -1);
    sendFrame(0, V_TOTAL, -1, 0, 1'b0, 1'b0, 1, -1);

    $display("[TB] asynchronous reset mid-frame");
    sendFrame(0, 3, -1, 0, 1'b0, 1'b0, -1, -1);
    for (int hc = 0; hc < 5; hc++) genPixel(3, hc, H_TOTAL, V_TOTAL, 1'b0, 1'b0);
    checkOutput("locked_before_reset", 64'(vid.locked), 64'd1);
    #10 clr_n = 1'b0;
    modelReset();
    #1 checkOutput("async_reset_outputs", packObs(), 64'd0);
    for (int hc = 5; hc < 8; hc++) genPixel(3, hc, H_TOTAL, V_TOTAL, 1'b0, 1'b0);
    clr_n = 1'b1;
    for (int hc = 8; hc < H_TOTAL; hc++) genPixel(3, hc, H_TOTAL, V_TOTAL, 1'b0, 1'b0);
    sendFrame(4, V_TOTAL, -1, 0, 1'b0, 1'b0, -1, -1);
    repeat (2) sendFrame(0, V_TOTAL, -1, 0, 1'b0, 1'b0, -1, -1);
    checkOutput("unlocked_before_relock", 64'(vid.locked), 64'd0);
    sendFrame(0, V_TOTAL, -1, 0, 1'b0, 1'b0, 1, -1);

    $display("[TB] hsync stuck high");
    sendFrame(0, 2, -1, 0, 1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 1030; i++) applyStimulus(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    checkOutput("stuck_hsync_unlocked", 64'(vid.locked), 64'd0);
    checkOutput("stuck_hsync_err", 64'(vid.err_cnt), 64'd1);
    checkOutput("stuck_hsync_invalid", 64'(vid.pix_valid), 64'd0);

    $display("[TB] randomized timing faults");
    for (int f = 0; f < 40; f++) begin
      int r, nl, sl, slen;
      bit ev;
      r    = int'($urandom_range(0, 5));
      nl   = (r == 0) ? V_TOTAL - 1 : ((r == 1) ? V_TOTAL + 1 : V_TOTAL);
      sl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      slen = H_TOTAL - 2 + int'($urandom_range(0, 4));
      ev   = ($urandom_range(0, 3) == 0);
      sendFrame(0, nl, sl, slen, ev, 1'b0, -1, -1);
    end

    $display("[TB] short frames until error counter saturates");
    repeat (270) sendFrame(0, V_TOTAL - 1, -1, 0, 1'b0, 1'b0, -1, -1);
    checkOutput("short_frames_unlocked", 64'(vid.locked), 64'd0);
    checkOutput("err_saturated", 64'(vid.err_cnt), 64'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
